// File: rtl/ppu_vram_port.sv
// rtl/ppu_vram_port.sv - PPU bus responder: nametable and palette RAM, CHR routing, CPU $2006/$2007 data port
module ppu_vram_port (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [13:0] ppubus_addr_i,
  output logic [7:0]  ppubus_data_o,
  input  logic        render_active_i,
  input  logic [2:0]  cpu_reg_i,
  input  logic        cpu_wr_i,
  input  logic        cpu_rd_i,
  input  logic [7:0]  cpu_wdata_i,
  output logic [7:0]  cpu_rdata_o,
  input  logic        inc32_i,
  input  logic        mirror_i,
  output logic [12:0] chr_addr_o,
  input  logic [7:0]  chr_data_i,
  output logic        chr_we_o,
  output logic [7:0]  chr_wdata_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_PEND,
    ST_RD_PEND,
    ST_RD_DATA
  } state_e;

  typedef enum logic [1:0] {
    RG_CHR,
    RG_NT,
    RG_PAL
  } region_e;

  function automatic region_e region_of(input logic [5:0] hi);
    if (hi == 6'h3F) begin
      region_of = RG_PAL;
    end else if (!hi[5]) begin
      region_of = RG_CHR;
    end else begin
      region_of = RG_NT;
    end
  endfunction

  // Bit 12 never reaches the index, so 0x3xxx mirrors 0x2xxx for free.
  function automatic logic [10:0] nt_index(input logic [11:0] a, input logic vert);
    nt_index = vert ? {a[10], a[9:0]} : {a[11], a[9:0]};
  endfunction

  // Sprite backdrop entries 0x10/0x14/0x18/0x1C share storage with 0x00/0x04/0x08/0x0C.
  function automatic logic [4:0] pal_index(input logic [4:0] a);
    pal_index = (a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
  endfunction

  logic [7:0] nt_mem [2048];
  logic [5:0] pal_mem [32];

  state_e      state_q, state_d;
  logic [13:0] v_q, v_d;
  logic        w_q, w_d;
  logic [7:0]  rbuf_q, rbuf_d;
  logic [13:0] pend_addr_q, pend_addr_d;
  logic [7:0]  pend_data_q, pend_data_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic [13:0] mem_addr_q, mem_addr_d;
  region_e     region2_q, region2_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        chr_we_q, chr_we_d;
  logic [7:0]  chr_wdata_q, chr_wdata_d;
  logic        chr_phase_q, chr_phase_d;

  logic        wr_en;
  logic        rd_en;
  logic        port_wr;
  logic        port_rd;
  logic        cpu_grant;
  logic        v_is_pal;
  logic [13:0] v_next;
  logic [7:0]  mem_rd_data;
  logic [7:0]  cpu_pal_data;
  region_e     mem_region;
  region_e     pend_region;
  logic        nt_we;
  logic        pal_we;

  always_comb begin
    wr_en        = cpu_wr_i;
    rd_en        = cpu_rd_i & ~cpu_wr_i;
    port_wr      = wr_en && (cpu_reg_i == 3'd7);
    port_rd      = rd_en && (cpu_reg_i == 3'd7);
    v_is_pal     = (v_q[13:8] == 6'h3F);
    v_next       = v_q + (inc32_i ? 14'd32 : 14'd1);
    cpu_pal_data = {2'b00, pal_mem[pal_index(v_q[4:0])]};
    cpu_grant    = ((state_q == ST_WR_PEND) || (state_q == ST_RD_PEND)) && !render_active_i;
    mem_addr_d   = cpu_grant ? pend_addr_q : ppubus_addr_i;
    mem_region   = region_of(mem_addr_q[13:8]);
    pend_region  = region_of(pend_addr_q[13:8]);
    if (mem_region == RG_PAL) begin
      mem_rd_data = {2'b00, pal_mem[pal_index(mem_addr_q[4:0])]};
    end else begin
      mem_rd_data = nt_mem[nt_index(mem_addr_q[11:0], mirror_i)];
    end
    rd_data_d = mem_rd_data;
    region2_d = mem_region;
  end

  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    w_d         = w_q;
    rbuf_d      = rbuf_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    cpu_rdata_d = cpu_rdata_q;
    chr_we_d    = 1'b0;
    chr_wdata_d = chr_wdata_q;
    chr_phase_d = chr_phase_q;
    nt_we       = 1'b0;
    pal_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (port_wr) begin
          pend_addr_d = v_q;
          pend_data_d = cpu_wdata_i;
          v_d         = v_next;
          state_d     = ST_WR_PEND;
        end else if (port_rd) begin
          cpu_rdata_d = v_is_pal ? cpu_pal_data : rbuf_q;
          // Palette reads still refill the buffer, from the nametable byte underneath.
          pend_addr_d = v_is_pal ? (v_q - 14'h1000) : v_q;
          v_d         = v_next;
          state_d     = ST_RD_PEND;
        end
      end
      ST_WR_PEND: begin
        if (!render_active_i) begin
          state_d = ST_IDLE;
          case (pend_region)
            RG_CHR: begin
              chr_we_d    = 1'b1;
              chr_wdata_d = pend_data_q;
            end
            RG_PAL:  pal_we = 1'b1;
            default: nt_we  = 1'b1;
          endcase
        end
      end
      ST_RD_PEND: begin
        if (!render_active_i) begin
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        // CHR data arrives one edge after the registered address, so wait a cycle for it.
        if (chr_phase_q) begin
          rbuf_d      = chr_data_i;
          chr_phase_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (mem_region == RG_CHR) begin
          chr_phase_d = 1'b1;
        end else begin
          rbuf_d  = mem_rd_data;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_en && (cpu_reg_i == 3'd6)) begin
      if (!w_q) begin
        v_d[13:8] = cpu_wdata_i[5:0];
        w_d       = 1'b1;
      end else begin
        v_d[7:0] = cpu_wdata_i;
        w_d      = 1'b0;
      end
    end
    if (rd_en && (cpu_reg_i == 3'd2)) begin
      w_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      v_q         <= 14'd0;
      w_q         <= 1'b0;
      rbuf_q      <= 8'd0;
      pend_addr_q <= 14'd0;
      pend_data_q <= 8'd0;
      cpu_rdata_q <= 8'd0;
      mem_addr_q  <= 14'd0;
      region2_q   <= RG_NT;
      rd_data_q   <= 8'd0;
      chr_we_q    <= 1'b0;
      chr_wdata_q <= 8'd0;
      chr_phase_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      w_q         <= w_d;
      rbuf_q      <= rbuf_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_addr_q  <= mem_addr_d;
      region2_q   <= region2_d;
      rd_data_q   <= rd_data_d;
      chr_we_q    <= chr_we_d;
      chr_wdata_q <= chr_wdata_d;
      chr_phase_q <= chr_phase_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && nt_we) begin
      nt_mem[nt_index(pend_addr_q[11:0], mirror_i)] <= pend_data_q;
    end
    if (!rst_i && pal_we) begin
      pal_mem[pal_index(pend_addr_q[4:0])] <= pend_data_q[5:0];
    end
  end

  assign ppubus_data_o = (region2_q == RG_CHR) ? chr_data_i : rd_data_q;
  assign cpu_rdata_o   = cpu_rdata_q;
  assign chr_addr_o    = mem_addr_q[12:0];
  assign chr_we_o      = chr_we_q;
  assign chr_wdata_o   = chr_wdata_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ppu_vram_port.sv
// tb/tb_ppu_vram_port.sv - scoreboard bench for ppu_vram_port
module tb_ppu_vram_port;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [13:0] ppubus_addr_i;
  logic [7:0]  ppubus_data_o;
  logic        render_active_i;
  logic [2:0]  cpu_reg_i;
  logic        cpu_wr_i;
  logic        cpu_rd_i;
  logic [7:0]  cpu_wdata_i;
  logic [7:0]  cpu_rdata_o;
  logic        inc32_i;
  logic        mirror_i;
  logic [12:0] chr_addr_o;
  logic [7:0]  chr_data_i;
  logic        chr_we_o;
  logic [7:0]  chr_wdata_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_rd_q [$];
  logic [7:0] exp_bus_q [$];
  logic [7:0] exp_v;
  logic       rd_chk = 1'b0;
  logic       fetch_chk = 1'b0;
  logic       rd_p = 1'b0;
  logic       f1 = 1'b0;
  logic       f2 = 1'b0;
  logic [7:0] chr_mem [8192];

  always #5 clk = ~clk;

  ppu_vram_port dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .ppubus_addr_i   (ppubus_addr_i),
    .ppubus_data_o   (ppubus_data_o),
    .render_active_i (render_active_i),
    .cpu_reg_i       (cpu_reg_i),
    .cpu_wr_i        (cpu_wr_i),
    .cpu_rd_i        (cpu_rd_i),
    .cpu_wdata_i     (cpu_wdata_i),
    .cpu_rdata_o     (cpu_rdata_o),
    .inc32_i         (inc32_i),
    .mirror_i        (mirror_i),
    .chr_addr_o      (chr_addr_o),
    .chr_data_i      (chr_data_i),
    .chr_we_o        (chr_we_o),
    .chr_wdata_o     (chr_wdata_o),
    .busy_o          (busy_o)
  );

  // External CHR-RAM with one-cycle registered read.
  always @(posedge clk) begin
    if (chr_we_o) chr_mem[chr_addr_o] <= chr_wdata_o;
    chr_data_i <= chr_mem[chr_addr_o];
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    rd_p <= rd_chk;
    f1   <= fetch_chk;
    f2   <= f1;
  end

  always @(negedge clk) begin
    if (rd_p) begin
      if (exp_rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cpu_rdata: got %h with no expected value queued", cpu_rdata_o);
      end else begin
        exp_v = exp_rd_q.pop_front();
        check("cpu_rdata", {8'h00, cpu_rdata_o}, {8'h00, exp_v});
      end
    end
    if (f2) begin
      if (exp_bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_data: got %h with no expected value queued", ppubus_data_o);
      end else begin
        exp_v = exp_bus_q.pop_front();
        check("bus_data", {8'h00, ppubus_data_o}, {8'h00, exp_v});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [2:0] r, input logic [7:0] d);
    cpu_reg_i   = r;
    cpu_wdata_i = d;
    cpu_wr_i    = 1'b1;
    tick();
    cpu_wr_i    = 1'b0;
  endtask

  task automatic cpu_rd(input logic [2:0] r, input logic chk, input logic [7:0] e);
    if (chk) exp_rd_q.push_back(e);
    rd_chk    = chk;
    cpu_reg_i = r;
    cpu_rd_i  = 1'b1;
    tick();
    cpu_rd_i  = 1'b0;
    rd_chk    = 1'b0;
  endtask

  task automatic fetch(input logic [13:0] a, input logic [7:0] e);
    exp_bus_q.push_back(e);
    ppubus_addr_i = a;
    fetch_chk     = 1'b1;
    tick();
    fetch_chk     = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!busy_o) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy_o still %b after 20 cycles, expected 0", busy_o);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) chr_mem[i] = 8'h00;
    chr_mem[13'h1234] = 8'hC3;
    rst_i = 1'b1;
    ppubus_addr_i = 14'h0000;
    render_active_i = 1'b0;
    cpu_reg_i = 3'd0;
    cpu_wr_i = 1'b0;
    cpu_rd_i = 1'b0;
    cpu_wdata_i = 8'h00;
    inc32_i = 1'b0;
    mirror_i = 1'b1;
    tick();
    tick();
    check("rst_bus_data", {8'h00, ppubus_data_o}, 16'h0000);
    check("rst_cpu_rdata", {8'h00, cpu_rdata_o}, 16'h0000);
    check("rst_chr_we", {15'd0, chr_we_o}, 16'h0000);
    check("rst_chr_addr", {3'd0, chr_addr_o}, 16'h0000);
    check("rst_chr_wdata", {8'h00, chr_wdata_o}, 16'h0000);
    check("rst_busy", {15'd0, busy_o}, 16'h0000);
    rst_i = 1'b0;
    tick();

    // Basic $2006/$2007 write, then v auto-increment
    cpu_wr(6, 8'h21); cpu_wr(6, 8'h08); cpu_wr(7, 8'h5A); wait_idle();
    cpu_wr(7, 8'hA5); wait_idle();
    fetch(14'h2108, 8'h5A); fetch(14'h2109, 8'hA5); fetch(14'h3108, 8'h5A);

    // Buffered reads and mirroring
    cpu_wr(6, 8'h20); cpu_wr(6, 8'h05); cpu_wr(7, 8'h77); wait_idle();
    cpu_wr(6, 8'h28); cpu_wr(6, 8'h05);
    cpu_rd(7, 1'b1, 8'h00); wait_idle();
    cpu_rd(7, 1'b1, 8'h77); wait_idle();
    mirror_i = 1'b0;
    fetch(14'h2405, 8'h77);
    cpu_wr(6, 8'h2C); cpu_wr(6, 8'h05); cpu_wr(7, 8'h3C); wait_idle();
    fetch(14'h2805, 8'h3C);
    tick(); tick();
    mirror_i = 1'b1;
    fetch(14'h2405, 8'h3C); fetch(14'h2005, 8'h77);

    // Palette: aliasing, 6-bit width, direct read with buffer refill from underneath
    cpu_wr(6, 8'h2F); cpu_wr(6, 8'h00); cpu_wr(7, 8'h99); wait_idle();
    cpu_wr(6, 8'h3F); cpu_wr(6, 8'h10); cpu_wr(7, 8'h2C); wait_idle();
    cpu_wr(6, 8'h3F); cpu_wr(6, 8'h01); cpu_wr(7, 8'hFF); wait_idle();
    cpu_wr(6, 8'h3F); cpu_wr(6, 8'h00);
    cpu_rd(7, 1'b1, 8'h2C); wait_idle();
    cpu_wr(6, 8'h21); cpu_wr(6, 8'h08);
    cpu_rd(7, 1'b1, 8'h99); wait_idle();
    cpu_rd(7, 1'b1, 8'h5A); wait_idle();
    cpu_rd(7, 1'b1, 8'hA5); wait_idle();
    fetch(14'h3F00, 8'h2C); fetch(14'h3F01, 8'h3F); fetch(14'h3F10, 8'h2C);

    // inc32 wrap, busy held by rendering, CHR write strobe
    inc32_i = 1'b1;
    render_active_i = 1'b1;
    cpu_wr(6, 8'h3F); cpu_wr(6, 8'hF0); cpu_wr(7, 8'h15);
    tick(); tick(); tick();
    check("busy_render_hold", {15'd0, busy_o}, 16'h0001);
    render_active_i = 1'b0;
    check("busy_before_edge", {15'd0, busy_o}, 16'h0001);
    tick();
    check("busy_after_drop", {15'd0, busy_o}, 16'h0000);
    cpu_wr(7, 8'h6B);
    tick();
    check("chr_we_pulse", {15'd0, chr_we_o}, 16'h0001);
    check("chr_addr_wrap", {3'd0, chr_addr_o}, 16'h0010);
    check("chr_wdata", {8'h00, chr_wdata_o}, 16'h006B);
    tick();
    check("chr_we_single", {15'd0, chr_we_o}, 16'h0000);
    inc32_i = 1'b0;
    fetch(14'h0010, 8'h6B); fetch(14'h3F00, 8'h15);

    // Render CHR fetch
    fetch(14'h1234, 8'hC3);

    // Strobe while busy is dropped
    render_active_i = 1'b1;
    cpu_wr(6, 8'h21); cpu_wr(6, 8'h10); cpu_wr(7, 8'h11);
    check("busy_pending", {15'd0, busy_o}, 16'h0001);
    cpu_wr(7, 8'h22);
    render_active_i = 1'b0;
    wait_idle();
    cpu_wr(7, 8'h33); wait_idle();
    fetch(14'h2110, 8'h11); fetch(14'h2111, 8'h33);

    // $2002 read resets the write toggle
    cpu_wr(6, 8'h21); cpu_rd(2, 1'b0, 8'h00);
    cpu_wr(6, 8'h23); cpu_wr(6, 8'h40); cpu_wr(7, 8'h44); wait_idle();
    fetch(14'h2340, 8'h44);

    // Reset aborts a pending write
    cpu_wr(6, 8'h22); cpu_wr(6, 8'h00); cpu_wr(7, 8'h10); wait_idle();
    render_active_i = 1'b1;
    cpu_wr(6, 8'h22); cpu_wr(6, 8'h00); cpu_wr(7, 8'h20);
    rst_i = 1'b1;
    tick();
    check("busy_after_reset", {15'd0, busy_o}, 16'h0000);
    rst_i = 1'b0;
    render_active_i = 1'b0;
    tick(); tick();
    fetch(14'h2200, 8'h10);

    tick(); tick(); tick(); tick();
    check("rd_queue_empty", exp_rd_q.size(), 16'h0000);
    check("bus_queue_empty", exp_bus_q.size(), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ppu_vram_port.md
# ppu_vram_port

Responder side of the PPU bus. It answers the 14-bit address that the background and sprite fetch logic drives each dot, with one-cycle registered read data. It also implements the CPU data port ($2006 address, $2007 data, and the $2002 write-latch reset) against the same memories. It contains the 2 KiB nametable RAM with mirroring and the 32-entry palette RAM, and routes pattern-table accesses to the external CHR port.

## Interface
- Parameters: none.
- clk_i  in  1  PPU clock.
- rst_i  in  1  synchronous, active-high reset.
- ppubus_addr_i  in  14  render fetch address, sampled every cycle.
- ppubus_data_o  out  8  read data for the address sampled on the previous edge.
- render_active_i  in  1  rendering is enabled and the dot is in a visible or pre-render line; render owns the bus.
- cpu_reg_i  in  3  CPU register index ($2000+n).
- cpu_wr_i  in  1  one-cycle CPU write strobe.
- cpu_rd_i  in  1  one-cycle CPU read strobe.
- cpu_wdata_i  in  8  CPU write data.
- cpu_rdata_o  out  8  $2007 read result, valid the cycle after cpu_rd_i.
- inc32_i  in  1  PPUCTRL bit 2: increment the data-port address by 32 instead of 1.
- mirror_i  in  1  0 = horizontal mirroring, 1 = vertical mirroring.
- chr_addr_o  out  13  CHR address.
- chr_data_i  in  8  CHR read data, valid one cycle after chr_addr_o.
- chr_we_o  out  1  CHR-RAM write strobe.
- chr_wdata_o  out  8  CHR write data.
- busy_o  out  1  a CPU $2007 access is pending.

## Operation
- Address decode on a 14-bit address a:
  - 0x0000–0x1FFF → CHR.
  - 0x2000–0x3EFF → nametable. Bit 12 is ignored, so 0x3000 mirrors 0x2000.
  - 0x3F00–0x3FFF → palette, index a[4:0]. Indices 0x10/0x14/0x18/0x1C alias 0x00/0x04/0x08/0x0C.
- Nametable RAM index: vertical mirroring uses {a[10], a[9:0]}; horizontal uses {a[11], a[9:0]}.
- Palette entries are 6 bits wide. Reads return {2'b00, entry}.
- Bus ownership:
  - While render_active_i=1, the memories are addressed by ppubus_addr_i.
  - Otherwise they are addressed by the pending CPU access if there is one, else by ppubus_addr_i.
- Data-port registers:
  - 14-bit address v.
  - Write toggle w.
  - 8-bit read buffer rbuf.
- $2006 write:
  - w=0: v[13:8] ← wdata[5:0], w ← 1.
  - w=1: v[7:0] ← wdata, w ← 0.
- $2002 read: w ← 0. It does not change v.
- $2007 write: capture wdata and v into the pending slot, then state WR_PEND.
- $2007 read:
  - cpu_rdata_o ← rbuf, except when v ≥ 0x3F00: cpu_rdata_o ← palette[v] directly.
  - Then state RD_PEND, capturing address v. For a palette address, the captured address is v − 0x1000, the nametable byte underneath.
- v increments by 1 or 32 (per inc32_i) at the moment the access is captured. It wraps modulo 2^14.
- FSM states:
  - IDLE → WR_PEND / RD_PEND on a $2007 strobe.
  - WR_PEND → IDLE in the first cycle with render_active_i=0. Write executes that cycle: nametable/palette RAM write, or chr_we_o=1 for one cycle.
  - RD_PEND → RD_DATA in the first cycle with render_active_i=0. Address is presented that cycle.
  - RD_DATA → IDLE: rbuf ← returned data.
- A $2007 strobe while busy_o=1 is dropped: no v increment, no state change.
- Simultaneous cpu_wr_i and cpu_rd_i: the write wins.
- Other cpu_reg_i values are ignored.

## Timing
- Render read latency is 1 cycle. ppubus_addr_i sampled at edge N → ppubus_data_o valid after edge N+1 and held until edge N+2.
- chr_addr_o is registered with the same cadence. chr_data_i is forwarded combinationally to ppubus_data_o for CHR addresses.
- CPU read result appears the cycle after cpu_rd_i.
- rbuf refresh takes 2 cycles after the access is granted.
- busy_o is asserted from the cycle after the strobe until the return to IDLE.
- Reset values:
  - v=0, w=0, rbuf=0.
  - State IDLE, busy_o=0.
  - ppubus_data_o=0, cpu_rdata_o=0.
  - chr_we_o=0, chr_addr_o=0, chr_wdata_o=0.
- RAM contents are not reset.
- Reset mid-access aborts the pending access. No write occurs after the reset edge.
- If render_active_i rises while in RD_DATA, the data still lands in rbuf because the address was already issued.

## Test plan
- Write $2006 ← 0x21, $2006 ← 0x08, then $2007 ← 0x5A with render_active_i=0 → nametable RAM[0x108] = 0x5A. Then v = 0x2109.
- With vertical mirroring, write 0x77 at 0x2005 and read 0x2805 twice via $2007 → first read returns the stale buffer, second returns 0x77. With mirror_i=0, the 0x2405 address aliases 0x2005 instead.
- Palette: write 0x3F10 ← 0x2C, then read 0x3F00 → cpu_rdata_o = 0x2C immediately. rbuf now holds the nametable byte at 0x2F00.
- inc32_i=1 and v=0x3FF0, $2007 write → v wraps to 0x0010. busy_o stays high while render_active_i=1 and clears 1 cycle after it drops.
- Render fetch: ppubus_addr_i = 0x1234 at edge N, chr_data_i = 0xC3 → ppubus_data_o = 0xC3 after edge N+1. Nametable fetch returns the stored byte with identical latency.
- A $2007 strobe during busy_o is dropped (v unchanged). A $2002 read between two $2006 writes makes the second write load the high byte.
